// File: rtl/dac_spi_tx.sv
// dac_spi_tx: buffers 12-bit audio samples and serialises each one as a
// 32-bit write-and-update command to an LTC2624 quad DAC. SPI phases are
// paced by the shared clockenable tick, so SCK runs at half the tick rate.
module dac_spi_tx #(
   parameter logic [3:0]  CHANNEL     = 4'b0000,
   parameter int unsigned TWOS_TO_BIN = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clockenable,
   input  logic [0:11] datos,
   input  logic        ready,
   output logic        mosi,
   output logic        sck,
   output logic        dac_cs,
   output logic        dac_clr,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   localparam int unsigned DATA_W  = 12;
   localparam int unsigned FRAME_W = 32;
   localparam int unsigned CNT_W   = 5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_FINISH
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   pend_q, pend_d;
   logic                pend_valid_q, pend_valid_d;
   logic [FRAME_W-1:0]  shreg_q, shreg_d;
   logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
   logic                mosi_q, mosi_d;
   logic                sck_q, sck_d;
   logic                cs_q, cs_d;
   logic                clr_q, clr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                overrun_q, overrun_d;

   logic [DATA_W-1:0]   sample_c;
   logic [FRAME_W-1:0]  frame_c;
   logic                consume_c;

   // Incoming sample, optionally converted from two's complement to offset binary
   always_comb begin
      sample_c = datos;
      if (TWOS_TO_BIN != 0) begin
         sample_c[DATA_W-1] = ~datos[0];
      end
   end

   // Command word: don't-care byte, write-and-update opcode, address, data, pad
   assign frame_c = {8'h00, 4'b0011, CHANNEL, pend_q, 4'h0};

   // Next-state logic: serial FSM advances on ticks, capture runs every clock
   always_comb begin
      state_d      = state_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      shreg_d      = shreg_q;
      bitcnt_d     = bitcnt_q;
      mosi_d       = mosi_q;
      sck_d        = sck_q;
      cs_d         = cs_q;
      clr_d        = 1'b1;
      busy_d       = busy_q;
      done_d       = 1'b0;
      overrun_d    = 1'b0;
      consume_c    = (state_q == S_IDLE) && clockenable && pend_valid_q;

      if (clockenable) begin
         case (state_q)
            S_IDLE: begin
               sck_d = 1'b0;
               cs_d  = 1'b1;
               if (pend_valid_q) begin
                  shreg_d  = frame_c;
                  mosi_d   = frame_c[FRAME_W-1];
                  cs_d     = 1'b0;
                  busy_d   = 1'b1;
                  bitcnt_d = '0;
                  state_d  = S_SETUP;
               end
            end
            S_SETUP: begin
               sck_d   = 1'b1;
               mosi_d  = shreg_q[FRAME_W-1];
               state_d = S_HIGH;
            end
            S_HIGH: begin
               // Falling SCK edge: present the next bit while the clock is low
               sck_d    = 1'b0;
               shreg_d  = shreg_q << 1;
               mosi_d   = shreg_q[FRAME_W-2];
               bitcnt_d = bitcnt_q + CNT_W'(1);
               if (bitcnt_q == CNT_W'(FRAME_W - 1)) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_SETUP;
               end
            end
            S_FINISH: begin
               cs_d    = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               mosi_d  = 1'b0;
               sck_d   = 1'b0;
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // Holding buffer: a new sample always wins; overrun only if a live entry is lost
      if (consume_c) begin
         pend_valid_d = 1'b0;
      end
      if (ready) begin
         pend_d       = sample_c;
         pend_valid_d = 1'b1;
         overrun_d    = pend_valid_q && !consume_c;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         shreg_q      <= '0;
         bitcnt_q     <= '0;
         mosi_q       <= 1'b0;
         sck_q        <= 1'b0;
         cs_q         <= 1'b1;
         clr_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         shreg_q      <= shreg_d;
         bitcnt_q     <= bitcnt_d;
         mosi_q       <= mosi_d;
         sck_q        <= sck_d;
         cs_q         <= cs_d;
         clr_q        <= clr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign mosi    = mosi_q;
   assign sck     = sck_q;
   assign dac_cs  = cs_q;
   assign dac_clr = clr_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: two instances (default parameters, and CHANNEL=F with
// no sign conversion) share one stimulus stream and are checked every cycle
// against a tick-indexed frame model, plus literal frame expectations.
module tb_dac_spi_tx;

   logic        clock;
   logic        reset;
   logic        clockenable;
   logic        ready;
   logic [0:11] datos;
   logic [1:0]  mosi_w, sck_w, cs_w, clr_w, busy_w, done_w, ovr_w;

   int checks = 0;
   int errors = 0;
   int tcnt   = 0;
   bit model_ok = 0;

   dac_spi_tx u0 (
      .clock(clock), .reset(reset), .clockenable(clockenable), .datos(datos), .ready(ready),
      .mosi(mosi_w[0]), .sck(sck_w[0]), .dac_cs(cs_w[0]), .dac_clr(clr_w[0]),
      .busy(busy_w[0]), .done(done_w[0]), .overrun(ovr_w[0])
   );

   dac_spi_tx #(.CHANNEL(4'hF), .TWOS_TO_BIN(0)) u1 (
      .clock(clock), .reset(reset), .clockenable(clockenable), .datos(datos), .ready(ready),
      .mosi(mosi_w[1]), .sck(sck_w[1]), .dac_cs(cs_w[1]), .dac_clr(clr_w[1]),
      .busy(busy_w[1]), .done(done_w[1]), .overrun(ovr_w[1])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   // A frame is 66 ticks: the start tick, 64 half-bit phases, then the finish tick.
   bit          act [2];
   int          idx [2];
   logic [31:0] frm [2];
   bit          pv  [2];
   logic [11:0] pend[2];
   bit          e_done[2];
   bit          e_ovr [2];
   bit          e_clr;

   function automatic logic [11:0] conv(input int i, input logic [11:0] v);
      if (i == 0) return v ^ 12'h800;
      return v;
   endfunction

   function automatic logic [31:0] mk(input int i, input logic [11:0] d);
      logic [3:0] ch;
      ch = (i == 0) ? 4'h0 : 4'hF;
      return {8'h00, 4'h3, ch, d, 4'h0};
   endfunction

   function automatic logic [6:0] expv(input int i);
      logic m, s, c, b;
      if (act[i]) begin
         s = idx[i][0];
         m = (idx[i] < 64) ? frm[i][31 - idx[i] / 2] : 1'b0;
         c = 1'b0;
         b = 1'b1;
      end else begin
         s = 1'b0; m = 1'b0; c = 1'b1; b = 1'b0;
      end
      return {m, s, c, e_clr, b, e_done[i], e_ovr[i]};
   endfunction

   always @(posedge clock) begin : model
      logic [11:0] din;
      bit cons;
      din = datos;
      for (int i = 0; i < 2; i++) begin
         e_done[i] = 0;
         e_ovr[i]  = 0;
         if (reset) begin
            act[i] = 0; idx[i] = 0; pv[i] = 0; pend[i] = '0;
         end else begin
            cons = !act[i] && clockenable && pv[i];
            e_ovr[i] = ready && pv[i] && !cons;
            if (clockenable && act[i]) begin
               if (idx[i] == 64) begin
                  act[i] = 0;
                  e_done[i] = 1;
               end else begin
                  idx[i]++;
               end
            end
            if (cons) begin
               frm[i] = mk(i, pend[i]); act[i] = 1; idx[i] = 0; pv[i] = 0;
            end
            if (ready) begin
               pend[i] = conv(i, din); pv[i] = 1;
            end
         end
      end
      e_clr = !reset;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clock) begin : compare
      logic [6:0] got, ex;
      if (model_ok) begin
         for (int i = 0; i < 2; i++) begin
            got = {mosi_w[i], sck_w[i], cs_w[i], clr_w[i], busy_w[i], done_w[i], ovr_w[i]};
            ex  = expv(i);
            checks++;
            if (got !== ex) begin
               errors++;
               $display("FAIL model dut%0d t=%0t got=%b exp=%b (mosi sck cs clr busy done ovr)",
                        i, $time, got, ex);
            end
         end
      end
   end

   // ---------------- SPI frame collector ----------------
   logic [31:0] sr[2];
   logic        prev_sck[2], prev_cs[2];
   int          nbits[2], done_cnt[2], ovr_cnt[2], cs_low[2];
   logic [31:0] fq0[$], fq1[$];

   always @(negedge clock) begin
      for (int i = 0; i < 2; i++) begin
         if (cs_w[i] === 1'b0 && prev_cs[i] === 1'b1) begin
            sr[i] = '0; nbits[i] = 0;
         end
         if (sck_w[i] === 1'b1 && prev_sck[i] === 1'b0) begin
            sr[i] = {sr[i][30:0], mosi_w[i]}; nbits[i]++;
         end
         if (done_w[i] === 1'b1) begin
            done_cnt[i]++;
            if (i == 0) fq0.push_back(sr[i]); else fq1.push_back(sr[i]);
         end
         if (ovr_w[i] === 1'b1) ovr_cnt[i]++;
         if (cs_w[i] === 1'b0) cs_low[i]++;
         prev_sck[i] = sck_w[i];
         prev_cs[i]  = cs_w[i];
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input bit r, input bit ce, input bit rd, input logic [11:0] d);
      @(negedge clock);
      reset = r; clockenable = ce; ready = rd; datos = d;
   endtask

   task automatic tick(input int per, input bit rd, input logic [11:0] d);
      tcnt++;
      step(1'b0, (per != 0) && (tcnt % per == 0), rd, d);
   endtask

   task automatic run(input int n, input int per);
      for (int k = 0; k < n; k++) tick(per, 1'b0, 12'h000);
   endtask

   task automatic expect_v(input string nm, input logic [31:0] got, input logic [31:0] ex);
      checks++;
      if (got !== ex) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", nm, got, ex);
      end
   endtask

   task automatic wait_frames(input int target, input int per, input string nm);
      int k;
      k = 0;
      while ((fq0.size() < target || fq1.size() < target) && k < 3000) begin
         tick(per, 1'b0, 12'h000);
         k++;
      end
      expect_v({nm, "_timeout"}, 32'(k >= 3000), 32'd0);
   endtask

   task automatic wait_busy(input int per, input string nm);
      int k;
      k = 0;
      while (busy_w[0] !== 1'b1 && k < 200) begin
         tick(per, 1'b0, 12'h000);
         k++;
      end
      expect_v({nm, "_busy_timeout"}, 32'(k >= 200), 32'd0);
   endtask

   task automatic wait_bits(input int n, input int per, input string nm);
      int k;
      k = 0;
      while (nbits[0] < n && k < 1000) begin
         tick(per, 1'b0, 12'h000);
         k++;
      end
      expect_v({nm, "_bits_timeout"}, 32'(k >= 1000), 32'd0);
   endtask

   function automatic logic [31:0] fget(input int i, input int n);
      if (i == 0) return (n < fq0.size()) ? fq0[n] : 32'hDEADBEEF;
      return (n < fq1.size()) ? fq1[n] : 32'hDEADBEEF;
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      logic [6:0] snap;
      bit changed;
      reset = 1'b1; clockenable = 1'b0; ready = 1'b0; datos = 12'h000;
      for (int i = 0; i < 2; i++) begin
         nbits[i] = 0; done_cnt[i] = 0; ovr_cnt[i] = 0; cs_low[i] = 0; sr[i] = '0;
      end

      // Reset values, then dac_clr release one clock after reset drops
      step(1, 0, 0, 12'h000);
      step(1, 0, 0, 12'h000);
      model_ok = 1;
      expect_v("reset_outs", 32'({mosi_w[0], sck_w[0], cs_w[0], clr_w[0], busy_w[0], done_w[0], ovr_w[0]}),
               32'b0010000);
      step(0, 0, 0, 12'h000);
      step(0, 0, 0, 12'h000);
      expect_v("dac_clr_release", 32'(clr_w[0]), 32'd1);

      // Full-scale positive sample, tick every 4 clocks
      cs_low[0] = 0; done_cnt[0] = 0;
      tick(4, 1, 12'h7FF);
      wait_frames(1, 4, "f7ff");
      run(8, 4);
      expect_v("frame_7ff_u0", fget(0, 0), 32'h0030FFF0);
      expect_v("frame_7ff_u1", fget(1, 0), 32'h003F7FF0);
      expect_v("done_count_7ff", 32'(done_cnt[0]), 32'd1);
      expect_v("cs_low_clocks", 32'(cs_low[0]), 32'd260);

      // Most-negative sample
      tick(4, 1, 12'h800);
      wait_frames(2, 4, "f800");
      run(8, 4);
      expect_v("frame_800_u0", fget(0, 1), 32'h00300000);
      expect_v("frame_800_u1", fget(1, 1), 32'h003F8000);

      // Three strobes during one frame: 222 is overwritten by 333
      ovr_cnt[0] = 0;
      tick(4, 1, 12'h111);
      wait_busy(4, "ovr");
      run(20, 4);
      tick(4, 1, 12'h222);
      run(20, 4);
      tick(4, 1, 12'h333);
      wait_frames(4, 4, "ovr");
      run(300, 4);
      expect_v("ovr_count", 32'(ovr_cnt[0]), 32'd1);
      expect_v("frame_111_u0", fget(0, 2), 32'h00309110);
      expect_v("frame_333_u0", fget(0, 3), 32'h0030B330);
      expect_v("frame_333_u1", fget(1, 3), 32'h003F3330);
      expect_v("no_222_frame", 32'(fq0.size()), 32'd4);

      // Strobe coincident with the tick that consumes the pending entry
      ovr_cnt[0] = 0;
      step(0, 0, 1, 12'h123);
      step(0, 0, 0, 12'h000);
      step(0, 1, 1, 12'hABC);
      wait_frames(6, 4, "coinc");
      run(8, 4);
      expect_v("coinc_no_ovr", 32'(ovr_cnt[0]), 32'd0);
      expect_v("frame_123_u0", fget(0, 4), 32'h00309230);
      expect_v("frame_abc_u0", fget(0, 5), 32'h00302BC0);
      expect_v("frame_abc_u1", fget(1, 5), 32'h003FABC0);

      // Reset at bit 10, with a sample pending
      done_cnt[0] = 0;
      tick(4, 1, 12'h456);
      wait_busy(4, "rst");
      tick(4, 1, 12'h789);
      wait_bits(10, 4, "rst");
      step(1, 0, 0, 12'h000);
      step(0, 0, 0, 12'h000);
      expect_v("rst_mid_outs", 32'({cs_w[0], sck_w[0], busy_w[0], clr_w[0]}), 32'b1000);
      run(600, 4);
      expect_v("rst_no_done", 32'(done_cnt[0]), 32'd0);
      expect_v("rst_pend_dropped", 32'(fq0.size()), 32'd6);

      // clockenable held low for 100 clocks mid-frame
      tick(4, 1, 12'h3C5);
      wait_busy(4, "frz");
      wait_bits(5, 4, "frz");
      step(0, 0, 0, 12'h000);
      snap = {mosi_w[0], sck_w[0], cs_w[0], clr_w[0], busy_w[0], done_w[0], ovr_w[0]};
      changed = 0;
      for (int k = 0; k < 100; k++) begin
         step(0, 0, 0, 12'h000);
         if ({mosi_w[0], sck_w[0], cs_w[0], clr_w[0], busy_w[0], done_w[0], ovr_w[0]} !== snap) changed = 1;
      end
      expect_v("freeze_stable", 32'(changed), 32'd0);
      wait_frames(7, 4, "frz");
      run(8, 4);
      expect_v("frame_3c5_u0", fget(0, 6), 32'h0030BC50);
      expect_v("frame_3c5_u1", fget(1, 6), 32'h003F3C50);

      // Continuous clockenable: SCK at clock/2
      cs_low[0] = 0;
      tick(1, 1, 12'h0F0);
      wait_frames(8, 1, "cont");
      run(4, 1);
      expect_v("frame_0f0_u0", fget(0, 7), 32'h00308F00);
      expect_v("frame_0f0_u1", fget(1, 7), 32'h003F0F00);
      expect_v("cont_cs_low", 32'(cs_low[0]), 32'd65);

      // Randomised traffic against the model
      for (int k = 0; k < 4000; k++) begin
         step($urandom_range(0, 2999) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 39) == 0, 12'($urandom));
      end
      run(800, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
